// File: rtl/hpdcache_pkg.sv
// Shared prefetcher types: cache-line address, stride and sequencer state encoding.
// No logic; widths here set the defaults of every block that imports this package.
// No flow control.
package hpdcache_pkg;

   localparam int unsigned HPDCACHE_NLINE_WIDTH = 26;
   localparam int unsigned HWPF_STRIDE_WIDTH    = 16;

   typedef logic [HPDCACHE_NLINE_WIDTH-1:0] hpdcache_nline_t;
   typedef logic [HWPF_STRIDE_WIDTH-1:0]    hwpf_stride_t;

   typedef enum logic [1:0] {
      HWPF_SEQ_IDLE  = 2'd0,
      HWPF_SEQ_ARMED = 2'd1,
      HWPF_SEQ_ISSUE = 2'd2
   } hwpf_seq_state_e;

endpackage

// File: rtl/hwpf_stride_snooper.sv
// Line snooper: flags a core access to the armed base line.
// Combinational, zero latency.
// No flow control; the caller qualifies the hit with the snoop valid.
module hwpf_stride_snooper
   import hpdcache_pkg::*;
#(
   parameter int unsigned NLINE_W = HPDCACHE_NLINE_WIDTH
) (
   input  logic               en_i,
   input  logic [NLINE_W-1:0] base_nline_i,
   input  logic [NLINE_W-1:0] snoop_addr_i,
   output logic               hit_o
);

   assign hit_o = en_i & (snoop_addr_i == base_nline_i);

endmodule

// File: rtl/hwpf_stride_sequencer.sv
// Stride-prefetch stream sequencer: arms on a base line, bursts base+k*stride requests.
// Latency: match -> first request valid 1 cycle; back-to-back requests with ready held high.
// Backpressure: request held valid and stable until req_ready_i; all outputs registered.
module hwpf_stride_sequencer
   import hpdcache_pkg::*;
#(
   parameter int unsigned NLINE_W  = HPDCACHE_NLINE_WIDTH,
   parameter int unsigned STRIDE_W = 16,
   parameter int unsigned NBLK_W   = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                cfg_en_i,
   input  logic [NLINE_W-1:0]  cfg_base_nline_i,
   input  logic [STRIDE_W-1:0] cfg_stride_i,
   input  logic [NBLK_W-1:0]   cfg_nblocks_i,
   input  logic                cfg_rearm_i,
   input  logic                snoop_valid_i,
   input  logic [NLINE_W-1:0]  snoop_nline_i,
   output logic                req_valid_o,
   input  logic                req_ready_i,
   output logic [NLINE_W-1:0]  req_nline_o,
   output logic                busy_o,
   output logic [NLINE_W-1:0]  base_nline_o,
   output logic                done_o
);

   hwpf_seq_state_e     state_q, state_d;
   logic [NLINE_W-1:0]  base_q, base_d;
   logic [NLINE_W-1:0]  line_q, line_d;
   logic [STRIDE_W-1:0] stride_q, stride_d;
   logic [NBLK_W-1:0]   nblk_q, nblk_d;
   logic [NBLK_W-1:0]   cnt_q, cnt_d;
   logic                rearm_q, rearm_d;
   logic                vld_q, vld_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;
   logic                snoop_hit;
   logic                match;
   logic                hsk;
   logic [NLINE_W-1:0]  stride_ext;

   hwpf_stride_snooper #(
      .NLINE_W (NLINE_W)
   ) u_snooper (
      .en_i         (state_q == HWPF_SEQ_ARMED),
      .base_nline_i (base_q),
      .snoop_addr_i (snoop_nline_i),
      .hit_o        (snoop_hit)
   );

   assign match      = snoop_valid_i & snoop_hit;
   assign hsk        = vld_q & req_ready_i;
   assign stride_ext = NLINE_W'(stride_q);

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      line_d   = line_q;
      stride_d = stride_q;
      nblk_d   = nblk_q;
      cnt_d    = cnt_q;
      rearm_d  = rearm_q;
      vld_d    = vld_q;
      done_d   = 1'b0;
      unique case (state_q)
         HWPF_SEQ_IDLE: begin
            if (cfg_en_i && (cfg_nblocks_i != '0)) begin
               state_d  = HWPF_SEQ_ARMED;
               base_d   = cfg_base_nline_i;
               stride_d = cfg_stride_i;
               nblk_d   = cfg_nblocks_i;
               rearm_d  = cfg_rearm_i;
            end
         end
         HWPF_SEQ_ARMED: begin
            if (!cfg_en_i) begin
               state_d = HWPF_SEQ_IDLE;
            end else if (match) begin
               state_d = HWPF_SEQ_ISSUE;
               line_d  = base_q + stride_ext;
               cnt_d   = '0;
               vld_d   = 1'b1;
            end
         end
         HWPF_SEQ_ISSUE: begin
            // The request is always pending here, so an abort waits for its handshake.
            if (hsk) begin
               if (!cfg_en_i) begin
                  state_d = HWPF_SEQ_IDLE;
                  vld_d   = 1'b0;
               end else if (cnt_q == nblk_q - NBLK_W'(1)) begin
                  state_d = rearm_q ? HWPF_SEQ_ARMED : HWPF_SEQ_IDLE;
                  base_d  = rearm_q ? line_q : base_q;
                  vld_d   = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  cnt_d  = cnt_q + NBLK_W'(1);
                  line_d = line_q + stride_ext;
               end
            end
         end
         default: begin
            state_d = HWPF_SEQ_IDLE;
            vld_d   = 1'b0;
         end
      endcase
      busy_d = (state_d != HWPF_SEQ_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= HWPF_SEQ_IDLE;
         base_q   <= '0;
         line_q   <= '0;
         stride_q <= '0;
         nblk_q   <= '0;
         cnt_q    <= '0;
         rearm_q  <= 1'b0;
         vld_q    <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         line_q   <= line_d;
         stride_q <= stride_d;
         nblk_q   <= nblk_d;
         cnt_q    <= cnt_d;
         rearm_q  <= rearm_d;
         vld_q    <= vld_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   assign req_valid_o  = vld_q;
   assign req_nline_o  = line_q;
   assign busy_o       = busy_q;
   assign base_nline_o = base_q;
   assign done_o       = done_q;

endmodule

// File: doc/hwpf_stride_sequencer.md
# hwpf_stride_sequencer

Sequencing controller for one stride-prefetch stream in the hardware prefetcher. It latches a base cache line, stride and burst length, and arms a line snooper on the base line. On a matching core access it issues a burst of prefetch requests at `base + k*stride` over a valid/ready handshake. It then optionally re-arms on the last prefetched line. It sits between the prefetcher configuration registers, the core request snoop bus and the prefetch request arbiter.

## Interface
Parameters:
- `NLINE_W`, default `hpdcache_pkg::HPDCACHE_NLINE_WIDTH`: cache-line address width.
- `STRIDE_W`, default 16: stride width, in cache lines, unsigned.
- `NBLK_W`, default 8: burst-length width.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `cfg_en_i`  in  1  stream enable.
- `cfg_base_nline_i`  in  NLINE_W  initial base line.
- `cfg_stride_i`  in  STRIDE_W  stride in lines.
- `cfg_nblocks_i`  in  NBLK_W  requests per burst.
- `cfg_rearm_i`  in  1  re-arm after each burst (continuous mode).
- `snoop_valid_i`  in  1  core access present on the snoop bus.
- `snoop_nline_i`  in  NLINE_W  line of the core access.
- `req_valid_o`  out  1  prefetch request valid.
- `req_ready_i`  in  1  arbiter accepts the request.
- `req_nline_o`  out  NLINE_W  line to prefetch.
- `busy_o`  out  1  state is not IDLE.
- `base_nline_o`  out  NLINE_W  current snoop base.
- `done_o`  out  1  one-cycle pulse after the last request of a burst is accepted.

## Operation
FSM states: IDLE, ARMED, ISSUE.

- **IDLE**
  - Entered on reset.
  - Go to ARMED when `cfg_en_i=1` and `cfg_nblocks_i!=0`.
  - On that transition, latch base, stride, nblocks and rearm.
  - With `cfg_nblocks_i=0`, stay in IDLE.
- **ARMED**
  - The snooper is enabled on the latched base.
  - A match means `snoop_valid_i=1` and `snoop_nline_i==base`.
  - On a match: go to ISSUE, set the request line to `base+stride`, clear the counter.
  - `cfg_en_i=0` returns to IDLE, and takes priority over a same-cycle match.
- **ISSUE**
  - `req_valid_o=1` with `req_nline_o` equal to the current line.
  - On a handshake (`req_valid_o & req_ready_i`): counter+1, line += stride.
  - On the handshake with counter `==nblocks-1`, leave ISSUE:
    - With rearm=1: go to ARMED, new base = the last line issued (`base + nblocks*stride`).
    - With rearm=0: go to IDLE.
    - In both cases `done_o` pulses in the next cycle.
  - Snoop traffic is ignored in ISSUE.
- Handshake rules
  - Once raised, `req_valid_o` stays high and `req_nline_o` stays stable until accepted.
  - `cfg_en_i=0` during ISSUE goes to IDLE on the next cycle if `req_valid_o` is not pending. Because `req_valid_o` is held until accepted, in practice the pending request completes its handshake first, then the FSM goes to IDLE.
  - An aborted burst does not pulse `done_o`.
- Arithmetic
  - Stride is zero-extended to NLINE_W.
  - All line sums wrap modulo 2^NLINE_W, with no saturation.
- Configuration inputs are only sampled on IDLE→ARMED. Changes while busy are ignored until the next IDLE.

## Timing
- Reset values: `req_valid_o=0`, `req_nline_o=0`, `busy_o=0`, `base_nline_o=0`, `done_o=0`; state is IDLE.
- Enable at cycle t gives ARMED at t+1. A snoop at t is not checked.
- A match at cycle t gives `req_valid_o=1` at t+1 (one-cycle latency, registered).
- With `req_ready_i` held high, there is one request per cycle, back to back. A burst of N occupies N cycles.
- `done_o` is registered and is high for exactly one cycle after the final handshake. The next state is ARMED, which can match again in that same cycle.
- All outputs are registered. There is no combinational path from `req_ready_i` to `req_valid_o`.

## Structure
- Shared package `hpdcache_pkg`:
  - `hpdcache_nline_t` (already present).
  - State enum `hwpf_seq_state_e`.
  - Stride type `hwpf_stride_t`.
- One sub-module: the existing `hwpf_stride_snooper`.
  - `en_i` = (state==ARMED).
  - `base_nline_i` = latched base.
  - `snoop_addr_i` = `snoop_nline_i`.
  - The sequencer gates its output with `snoop_valid_i`.

## Test plan
1. Base 0x100, stride 2, N=3, rearm=0, ready=1; snoop 0x100 → requests 0x102, 0x104, 0x106 on consecutive cycles, then `done_o` pulse, then IDLE.
2. Same configuration with ready toggling 1-0-0-1 → each request is held stable while ready=0; all 3 lines are issued in order, with no duplicates and no drops.
3. Rearm=1, base 0x10, stride 1, N=2 → first burst 0x11, 0x12; `base_nline_o=0x12`; a snoop of 0x12 issues 0x13, 0x14; snoops of 0x11 are ignored.
4. Base 2^NLINE_W−2, stride 3, N=2 → requests 0x001 and 0x004 (wrap-around).
5. Enable drop during ISSUE with request pending and ready=0 → request held; ready=1 accepts it; then IDLE with no `done_o`. Enable drop in ARMED with a same-cycle match → IDLE, no request.
6. Reset asserted mid-burst → next cycle all outputs 0, state IDLE. `cfg_nblocks_i=0` with enable → stays IDLE, `busy_o=0`.
